// File: rtl/execute_unit.sv
// ----------------------------------------------------------------------------
// execute_unit
// Execute stage sitting directly behind decode. Takes one decoded instruction
// per toggle/ready handshake, evaluates the ARM condition field against the
// live CPSR flags, runs the data-processing ALU op or branch, and hands the
// result to the register bank over a second toggle/ready handshake.
//
// Ports
//   clk, reset          sole clock; synchronous active-high reset
//   dataIn1             instruction word: cond[31:28], L/op[24:21], S[20], Rd[15:12]
//   dataIn2             operand A (Rn value, or PC for branches)
//   dataIn3             operand B (shifted op2, or branch offset)
//   dataIn4             bit0 = shifter carry-out; branch: link return address
//   typeIn              0 = data-proc, 1 = branch, anything else = NOP
//   readyIn             decode valid (async level)
//   triggerOut          toggles once per consumed instruction
//   cpsrIn              current CPSR, NZCV at [31:28]
//   cpsrOut, cpsrWe     updated CPSR and its one-cycle commit strobe
//   dataOutWB, addrWB   writeback data and register index
//   triggerOutWB        toggles once per writeback request
//   readyInWB           regbank write ack (async level)
//   branchTaken         one-cycle pulse on a taken branch
// ----------------------------------------------------------------------------
module execute_unit #(
    parameter int SYNC_STAGES = 2,
    parameter int PC_REG      = 15,
    parameter int LR_REG      = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataIn1,
    input  logic [31:0] dataIn2,
    input  logic [31:0] dataIn3,
    input  logic [31:0] dataIn4,
    input  logic [3:0]  typeIn,
    input  logic        readyIn,
    output logic        triggerOut,
    input  logic [31:0] cpsrIn,
    output logic [31:0] cpsrOut,
    output logic        cpsrWe,
    output logic [31:0] dataOutWB,
    output logic [31:0] addrWB,
    output logic        triggerOutWB,
    input  logic        readyInWB,
    output logic        branchTaken
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DROP,
        S_EXEC,
        S_WBACK,
        S_WBREL
    } state_t;

    state_t r_state;

    // Synchronizers for the two asynchronous ready levels
    logic [SYNC_STAGES-1:0] r_rdy_sync;
    logic [SYNC_STAGES-1:0] r_wbr_sync;
    logic                   w_rdy_s;
    logic                   w_wbr_s;

    // Captured instruction fields
    logic [3:0]  r_cond;
    logic [3:0]  r_op;      // r_op[3] doubles as the branch L bit
    logic        r_s;
    logic [3:0]  r_rd;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_d4;
    logic [3:0]  r_type;
    logic        r_pend_pc; // PC write still owed after the LR write of a BL

    // ALU datapath
    logic [31:0] w_x;
    logic [31:0] w_y;
    logic        w_ci;
    logic        w_arith;
    logic [31:0] w_logic_res;
    logic [32:0] w_sum;
    logic [31:0] w_result;
    logic        w_n;
    logic        w_z;
    logic        w_c;
    logic        w_v;
    logic        w_wr;
    logic        w_cond_pass;
    logic [31:0] w_target;
    logic        w_fn;
    logic        w_fz;
    logic        w_fc;
    logic        w_fv;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdy_sync <= '0;
            r_wbr_sync <= '0;
        end else begin
            r_rdy_sync <= {r_rdy_sync[SYNC_STAGES-2:0], readyIn};
            r_wbr_sync <= {r_wbr_sync[SYNC_STAGES-2:0], readyInWB};
        end
    end

    assign w_rdy_s = r_rdy_sync[SYNC_STAGES-1];
    assign w_wbr_s = r_wbr_sync[SYNC_STAGES-1];

    assign w_fn = cpsrIn[31];
    assign w_fz = cpsrIn[30];
    assign w_fc = cpsrIn[29];
    assign w_fv = cpsrIn[28];

    always_comb begin
        w_cond_pass = 1'b0;
        case (r_cond)
            4'h0:    w_cond_pass = w_fz;
            4'h1:    w_cond_pass = !w_fz;
            4'h2:    w_cond_pass = w_fc;
            4'h3:    w_cond_pass = !w_fc;
            4'h4:    w_cond_pass = w_fn;
            4'h5:    w_cond_pass = !w_fn;
            4'h6:    w_cond_pass = w_fv;
            4'h7:    w_cond_pass = !w_fv;
            4'h8:    w_cond_pass = w_fc && !w_fz;
            4'h9:    w_cond_pass = !w_fc || w_fz;
            4'hA:    w_cond_pass = (w_fn == w_fv);
            4'hB:    w_cond_pass = (w_fn != w_fv);
            4'hC:    w_cond_pass = !w_fz && (w_fn == w_fv);
            4'hD:    w_cond_pass = w_fz || (w_fn != w_fv);
            4'hE:    w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;  // cond 15 executes as NOP
        endcase
    end

    // Subtractions are folded into one adder as x + ~y + carry-in, so the
    // adder carry-out is directly the ARM NOT-borrow C flag.
    always_comb begin
        w_x         = r_a;
        w_y         = r_b;
        w_ci        = 1'b0;
        w_arith     = 1'b1;
        w_logic_res = '0;
        case (r_op)
            4'h0: begin w_arith = 1'b0; w_logic_res = r_a & r_b;  end  // AND
            4'h1: begin w_arith = 1'b0; w_logic_res = r_a ^ r_b;  end  // EOR
            4'h2: begin w_y = ~r_b; w_ci = 1'b1;                  end  // SUB
            4'h3: begin w_x = r_b; w_y = ~r_a; w_ci = 1'b1;       end  // RSB
            4'h4: begin w_ci = 1'b0;                              end  // ADD
            4'h5: begin w_ci = w_fc;                              end  // ADC
            4'h6: begin w_y = ~r_b; w_ci = w_fc;                  end  // SBC
            4'h7: begin w_x = r_b; w_y = ~r_a; w_ci = w_fc;       end  // RSC
            4'h8: begin w_arith = 1'b0; w_logic_res = r_a & r_b;  end  // TST
            4'h9: begin w_arith = 1'b0; w_logic_res = r_a ^ r_b;  end  // TEQ
            4'hA: begin w_y = ~r_b; w_ci = 1'b1;                  end  // CMP
            4'hB: begin w_ci = 1'b0;                              end  // CMN
            4'hC: begin w_arith = 1'b0; w_logic_res = r_a | r_b;  end  // ORR
            4'hD: begin w_arith = 1'b0; w_logic_res = r_b;        end  // MOV
            4'hE: begin w_arith = 1'b0; w_logic_res = r_a & ~r_b; end  // BIC
            default: begin w_arith = 1'b0; w_logic_res = ~r_b;    end  // MVN
        endcase
    end

    assign w_sum    = {1'b0, w_x} + {1'b0, w_y} + {32'd0, w_ci};
    assign w_result = w_arith ? w_sum[31:0] : w_logic_res;
    assign w_n      = w_result[31];
    assign w_z      = (w_result == 32'd0);
    assign w_c      = w_arith ? w_sum[32] : r_d4[0];
    assign w_v      = w_arith ? ((w_x[31] == w_y[31]) && (w_sum[31] != w_x[31])) : w_fv;
    assign w_wr     = (r_op[3:2] != 2'b10);  // TST/TEQ/CMP/CMN only set flags
    assign w_target = r_a + r_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_WAIT;
            triggerOut   <= 1'b0;
            triggerOutWB <= 1'b0;
            cpsrWe       <= 1'b0;
            branchTaken  <= 1'b0;
            cpsrOut      <= '0;
            dataOutWB    <= '0;
            addrWB       <= '0;
            r_cond       <= '0;
            r_op         <= '0;
            r_s          <= 1'b0;
            r_rd         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_d4         <= '0;
            r_type       <= '0;
            r_pend_pc    <= 1'b0;
        end else begin
            cpsrWe      <= 1'b0;
            branchTaken <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    if (w_rdy_s) begin
                        r_cond     <= dataIn1[31:28];
                        r_op       <= dataIn1[24:21];
                        r_s        <= dataIn1[20];
                        r_rd       <= dataIn1[15:12];
                        r_a        <= dataIn2;
                        r_b        <= dataIn3;
                        r_d4       <= dataIn4;
                        r_type     <= typeIn;
                        triggerOut <= ~triggerOut;
                        r_state    <= S_DROP;
                    end
                end
                S_DROP: begin
                    if (!w_rdy_s) r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_state <= S_WAIT;
                    if (w_cond_pass && r_type == 4'd0) begin
                        if (r_s) begin
                            cpsrWe  <= 1'b1;
                            cpsrOut <= {w_n, w_z, w_c, w_v, cpsrIn[27:0]};
                        end
                        if (w_wr) begin
                            dataOutWB    <= w_result;
                            addrWB       <= {28'd0, r_rd};
                            triggerOutWB <= ~triggerOutWB;
                            r_state      <= S_WBACK;
                        end
                    end else if (w_cond_pass && r_type == 4'd1) begin
                        branchTaken  <= 1'b1;
                        triggerOutWB <= ~triggerOutWB;
                        r_state      <= S_WBACK;
                        if (r_op[3]) begin
                            // Link write goes first; PC write is issued from S_WBREL
                            dataOutWB <= r_d4;
                            addrWB    <= 32'(LR_REG);
                            r_pend_pc <= 1'b1;
                        end else begin
                            dataOutWB <= w_target;
                            addrWB    <= 32'(PC_REG);
                        end
                    end
                end
                S_WBACK: begin
                    if (w_wbr_s) r_state <= S_WBREL;
                end
                S_WBREL: begin
                    if (!w_wbr_s) begin
                        if (r_pend_pc) begin
                            r_pend_pc    <= 1'b0;
                            dataOutWB    <= w_target;
                            addrWB       <= 32'(PC_REG);
                            triggerOutWB <= ~triggerOutWB;
                            r_state      <= S_WBACK;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
module tb_execute_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataIn1, dataIn2, dataIn3, dataIn4;
    logic [3:0]  typeIn;
    logic        readyIn;
    logic        triggerOut;
    logic [31:0] cpsrIn;
    logic [31:0] cpsrOut;
    logic        cpsrWe;
    logic [31:0] dataOutWB;
    logic [31:0] addrWB;
    logic        triggerOutWB;
    logic        readyInWB;
    logic        branchTaken;

    int n_checks = 0;
    int n_errors = 0;

    // Event counters sampled on the falling edge
    int   cnt_trig   = 0;
    int   cnt_wbtrig = 0;
    int   cnt_we     = 0;
    int   cnt_bt     = 0;
    logic [31:0] last_cpsr = '0;
    logic prev_trig   = 1'b0;
    logic prev_wbtrig = 1'b0;

    execute_unit #(
        .SYNC_STAGES(2),
        .PC_REG     (15),
        .LR_REG     (14)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dataIn1     (dataIn1),
        .dataIn2     (dataIn2),
        .dataIn3     (dataIn3),
        .dataIn4     (dataIn4),
        .typeIn      (typeIn),
        .readyIn     (readyIn),
        .triggerOut  (triggerOut),
        .cpsrIn      (cpsrIn),
        .cpsrOut     (cpsrOut),
        .cpsrWe      (cpsrWe),
        .dataOutWB   (dataOutWB),
        .addrWB      (addrWB),
        .triggerOutWB(triggerOutWB),
        .readyInWB   (readyInWB),
        .branchTaken (branchTaken)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (triggerOut !== prev_trig) cnt_trig++;
        if (triggerOutWB !== prev_wbtrig) cnt_wbtrig++;
        prev_trig   = triggerOut;
        prev_wbtrig = triggerOutWB;
        if (cpsrWe === 1'b1) begin
            cnt_we++;
            last_cpsr = cpsrOut;
        end
        if (branchTaken === 1'b1) cnt_bt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic logic [31:0] dp(input logic [3:0] cond, input logic [3:0] op,
                                       input logic s, input logic [3:0] rd);
        return {cond, 3'b000, op, s, 4'h0, rd, 12'h000};
    endfunction

    // Present one instruction and complete the decode-side handshake.
    task automatic send_instr(input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] d3, input logic [31:0] d4,
                              input logic [3:0] ty, output bit ok);
        logic t0;
        @(negedge clk);
        dataIn1 = d1; dataIn2 = d2; dataIn3 = d3; dataIn4 = d4; typeIn = ty;
        t0 = triggerOut;
        readyIn = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (triggerOut !== t0) begin
                ok = 1'b1;
                break;
            end
        end
        readyIn = 1'b0;
        // Captured values must be used, not these
        dataIn1 = 32'hDEADBEEF; dataIn2 = 32'hDEADBEEF; dataIn3 = 32'hDEADBEEF;
        dataIn4 = 32'hDEADBEEF; typeIn = 4'h0;
    endtask

    // Wait for a writeback request and acknowledge it after 'delay' cycles.
    task automatic do_wb(input int delay, output bit ok, output logic [31:0] addr,
                         output logic [31:0] data, output bit stable);
        logic t0;
        t0 = triggerOutWB;
        ok = 1'b0;
        stable = 1'b1;
        addr = '0;
        data = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (triggerOutWB !== t0) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            addr = addrWB;
            data = dataOutWB;
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                if (addrWB !== addr || dataOutWB !== data) stable = 1'b0;
            end
            readyInWB = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (addrWB !== addr || dataOutWB !== data) stable = 1'b0;
            end
            readyInWB = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        readyIn = 1'b0; readyInWB = 1'b0;
        dataIn1 = '0; dataIn2 = '0; dataIn3 = '0; dataIn4 = '0; typeIn = '0; cpsrIn = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (triggerOut !== 1'b0) begin
            n_errors++; $display("FAIL reset_trig: got %b required 0", triggerOut);
        end
        n_checks++;
        if (triggerOutWB !== 1'b0) begin
            n_errors++; $display("FAIL reset_wbtrig: got %b required 0", triggerOutWB);
        end
        n_checks++;
        if ({cpsrWe, branchTaken} !== 2'b00) begin
            n_errors++; $display("FAIL reset_pulses: got %b required 00", {cpsrWe, branchTaken});
        end
        n_checks++;
        if ({cpsrOut, dataOutWB, addrWB} !== 96'd0) begin
            n_errors++;
            $display("FAIL reset_data: got %h %h %h required 0 0 0", cpsrOut, dataOutWB, addrWB);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_adds;
        bit ok, st;
        logic [31:0] a, d;
        int we0;
        we0 = cnt_we;
        cpsrIn = 32'h000000D3;
        send_instr(dp(4'hE, 4'h4, 1'b1, 4'd1), 32'h7FFFFFFF, 32'h1, 32'h0, 4'd0, ok);
        do_wb(0, ok, a, d, st);
        repeat (6) @(negedge clk);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL adds_wb_req: got none required toggle"); end
        n_checks++;
        if (a !== 32'd1) begin n_errors++; $display("FAIL adds_addr: got %h required 1", a); end
        n_checks++;
        if (d !== 32'h80000000) begin
            n_errors++; $display("FAIL adds_data: got %h required 80000000", d);
        end
        n_checks++;
        if (cnt_we - we0 != 1) begin
            n_errors++; $display("FAIL adds_we_count: got %0d required 1", cnt_we - we0);
        end
        n_checks++;
        if (last_cpsr !== 32'h900000D3) begin
            n_errors++; $display("FAIL adds_cpsr: got %h required 900000D3", last_cpsr);
        end
    endtask

    task automatic test_subs_cmp;
        bit ok, st;
        logic [31:0] a, d;
        int we0, wb0;
        cpsrIn = 32'h0;
        we0 = cnt_we;
        send_instr(dp(4'hE, 4'h2, 1'b1, 4'd2), 32'd5, 32'd5, 32'h0, 4'd0, ok);
        do_wb(0, ok, a, d, st);
        repeat (6) @(negedge clk);
        n_checks++;
        if (!ok || a !== 32'd2 || d !== 32'd0) begin
            n_errors++; $display("FAIL subs_wb: got ok=%0d %h/%h required 1 2/0", ok, a, d);
        end
        n_checks++;
        if (cnt_we - we0 != 1 || last_cpsr !== 32'h60000000) begin
            n_errors++;
            $display("FAIL subs_flags: got %0d %h required 1 60000000", cnt_we - we0, last_cpsr);
        end
        // CMP 3,5: flags only, no writeback
        we0 = cnt_we;
        wb0 = cnt_wbtrig;
        send_instr(dp(4'hE, 4'hA, 1'b1, 4'd0), 32'd3, 32'd5, 32'h0, 4'd0, ok);
        repeat (12) @(negedge clk);
        n_checks++;
        if (cnt_wbtrig != wb0) begin
            n_errors++; $display("FAIL cmp_no_wb: got %0d toggles required 0", cnt_wbtrig - wb0);
        end
        n_checks++;
        if (cnt_we - we0 != 1 || last_cpsr !== 32'h80000000) begin
            n_errors++;
            $display("FAIL cmp_flags: got %0d %h required 1 80000000", cnt_we - we0, last_cpsr);
        end
        // ANDS: logical C from shifter carry, V kept from cpsrIn
        cpsrIn = 32'h10000000;
        we0 = cnt_we;
        send_instr(dp(4'hE, 4'h0, 1'b1, 4'd3), 32'hF0, 32'h0F, 32'h1, 4'd0, ok);
        do_wb(0, ok, a, d, st);
        repeat (6) @(negedge clk);
        n_checks++;
        if (!ok || a !== 32'd3 || d !== 32'd0 || last_cpsr !== 32'h70000000) begin
            n_errors++;
            $display("FAIL ands: got ok=%0d %h/%h cpsr %h required 1 3/0 cpsr 70000000",
                     ok, a, d, last_cpsr);
        end
    endtask

    task automatic test_cond;
        bit ok, st;
        logic [31:0] a, d;
        int t0, wb0, we0;
        // MOVEQ with Z clear: squashed
        cpsrIn = 32'h0;
        t0 = cnt_trig; wb0 = cnt_wbtrig; we0 = cnt_we;
        send_instr(dp(4'h0, 4'hD, 1'b1, 4'd4), 32'h0, 32'h55, 32'h0, 4'd0, ok);
        repeat (12) @(negedge clk);
        n_checks++;
        if (cnt_trig - t0 != 1) begin
            n_errors++; $display("FAIL moveq_trig: got %0d toggles required 1", cnt_trig - t0);
        end
        n_checks++;
        if (cnt_wbtrig != wb0 || cnt_we != we0) begin
            n_errors++;
            $display("FAIL moveq_squash: got wb %0d we %0d required 0 0",
                     cnt_wbtrig - wb0, cnt_we - we0);
        end
        // MOVEQ with Z set, no S: write, no flag update
        cpsrIn = 32'h40000000;
        we0 = cnt_we;
        send_instr(dp(4'h0, 4'hD, 1'b0, 4'd4), 32'h12345678, 32'h55, 32'h0, 4'd0, ok);
        do_wb(0, ok, a, d, st);
        repeat (6) @(negedge clk);
        n_checks++;
        if (!ok || a !== 32'd4 || d !== 32'h55 || cnt_we != we0) begin
            n_errors++;
            $display("FAIL moveq_taken: got ok=%0d %h/%h we %0d required 1 4/55 0",
                     ok, a, d, cnt_we - we0);
        end
        cpsrIn = 32'h0;
    endtask

    task automatic test_bl;
        bit ok1, ok2, st;
        logic [31:0] a1, d1, a2, d2;
        int bt0, we0;
        bt0 = cnt_bt; we0 = cnt_we;
        send_instr({4'hE, 3'b101, 1'b1, 24'h000008}, 32'h100, 32'h20, 32'h104, 4'd1, ok1);
        do_wb(0, ok1, a1, d1, st);
        do_wb(0, ok2, a2, d2, st);
        repeat (6) @(negedge clk);
        n_checks++;
        if (!ok1 || a1 !== 32'd14 || d1 !== 32'h104) begin
            n_errors++; $display("FAIL bl_lr: got ok=%0d %h/%h required 1 e/104", ok1, a1, d1);
        end
        n_checks++;
        if (!ok2 || a2 !== 32'd15 || d2 !== 32'h120) begin
            n_errors++; $display("FAIL bl_pc: got ok=%0d %h/%h required 1 f/120", ok2, a2, d2);
        end
        n_checks++;
        if (cnt_bt - bt0 != 1) begin
            n_errors++; $display("FAIL bl_taken_pulse: got %0d cycles required 1", cnt_bt - bt0);
        end
        n_checks++;
        if (cnt_we != we0) begin
            n_errors++; $display("FAIL bl_flags: got %0d cpsrWe required 0", cnt_we - we0);
        end
    endtask

    task automatic test_back_to_back;
        bit ok, st;
        logic [31:0] a, d;
        int t0, wb0;
        t0 = cnt_trig; wb0 = cnt_wbtrig;
        @(negedge clk);
        dataIn1 = dp(4'hE, 4'h4, 1'b0, 4'd7); dataIn2 = 32'h11; dataIn3 = 32'h22;
        dataIn4 = 32'h0; typeIn = 4'd0;
        readyIn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) dataIn2 = 32'h999;
        end
        n_checks++;
        if (cnt_trig - t0 != 1) begin
            n_errors++; $display("FAIL hold_ready_capture: got %0d required 1", cnt_trig - t0);
        end
        n_checks++;
        if (cnt_wbtrig != wb0) begin
            n_errors++; $display("FAIL hold_ready_stall: got %0d wb toggles required 0",
                                 cnt_wbtrig - wb0);
        end
        readyIn = 1'b0;
        do_wb(10, ok, a, d, st);
        repeat (6) @(negedge clk);
        n_checks++;
        if (!ok || a !== 32'd7 || d !== 32'h33) begin
            n_errors++; $display("FAIL slow_wb: got ok=%0d %h/%h required 1 7/33", ok, a, d);
        end
        n_checks++;
        if (!st) begin n_errors++; $display("FAIL wb_stable: got changed required stable"); end
        n_checks++;
        if (cnt_trig - t0 != 1) begin
            n_errors++; $display("FAIL one_capture: got %0d required 1", cnt_trig - t0);
        end
    endtask

    task automatic test_reset_mid;
        bit ok, st, seen;
        logic [31:0] a, d;
        logic w0;
        // Make sure triggerOutWB ends up high before the reset
        if (triggerOutWB === 1'b1) begin
            send_instr(dp(4'hE, 4'hD, 1'b0, 4'd8), 32'h0, 32'h1, 32'h0, 4'd0, ok);
            do_wb(0, ok, a, d, st);
        end
        cpsrIn = 32'h0;
        w0 = triggerOutWB;
        send_instr(dp(4'hE, 4'h4, 1'b1, 4'd5), 32'd2, 32'd3, 32'h0, 4'd0, ok);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (triggerOutWB !== w0) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL rst_mid_req: got none required toggle"); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({triggerOut, triggerOutWB, cpsrWe, branchTaken} !== 4'b0000) begin
            n_errors++;
            $display("FAIL rst_mid_ctrl: got %b required 0000",
                     {triggerOut, triggerOutWB, cpsrWe, branchTaken});
        end
        n_checks++;
        if ({cpsrOut, dataOutWB, addrWB} !== 96'd0) begin
            n_errors++;
            $display("FAIL rst_mid_data: got %h %h %h required 0 0 0", cpsrOut, dataOutWB, addrWB);
        end
        reset = 1'b0;
        @(negedge clk);
        send_instr(dp(4'hE, 4'h4, 1'b0, 4'd6), 32'd7, 32'd8, 32'h0, 4'd0, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL rst_after_accept: got none required toggle"); end
        do_wb(0, ok, a, d, st);
        n_checks++;
        if (!ok || a !== 32'd6 || d !== 32'd15) begin
            n_errors++; $display("FAIL rst_after_wb: got ok=%0d %h/%h required 1 6/f", ok, a, d);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_adds();
        test_subs_cmp();
        test_cond();
        test_bl();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
